// File: rtl/seg7_rtc_pkg.sv
// Shared constants and helpers for the seven-segment real-time clock.
package seg7_rtc_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit limits
    localparam logic [3:0] UNITS_MAX           = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX        = 4'd5;
    localparam logic [3:0] HOUR_MAX_TENS       = 4'd2;
    localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Largest legal value of digit idx; hour units depend on the hour tens value
    function automatic logic [3:0] digit_max(input int unsigned idx, input int unsigned nd,
                                             input logic [3:0] hrs_tens);
        if (nd == 6 && idx == 5) return HOUR_MAX_TENS;
        if (nd == 6 && idx == 4) begin
            return (hrs_tens == HOUR_MAX_TENS) ? HOUR_MAX_UNITS_AT_2 : UNITS_MAX;
        end
        return (idx % 2 == 1) ? SEC_TENS_MAX : UNITS_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit with programmable maximum, parallel load and ripple carry-out.
module bcd_digit_cnt (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_inc,
    input  logic [3:0] i_max,
    output logic [3:0] o_val,
    output logic       o_carry
);
    logic [3:0] r_val;

    // Digit register: load wins over increment, wrap to 0 past the maximum
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val <= 4'd0;
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_inc) begin
            r_val <= (r_val >= i_max) ? 4'd0 : r_val + 4'd1;
        end
    end

    assign o_val   = r_val;
    assign o_carry = i_inc && (r_val >= i_max);

endmodule

// File: rtl/seg7_rtc_scan.sv
// BCD time-of-day clock (MM:SS or HH:MM:SS) driving a multiplexed common-anode display.
// Optional: define LEADING_ZERO_BLANK_EN to blank the most significant digit when it is 0.
module seg7_rtc_scan
    import seg7_rtc_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_run,
    input  logic                    i_load_valid,
    input  logic [4*NUM_DIGITS-1:0] i_load_bcd,
    output logic                    o_load_ready,
    output logic                    o_load_err,
    output logic                    o_sec_pulse,
    output logic [6:0]              o_segments,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_anodes
);
    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]         r_presc;
    logic [SW-1:0]         r_scan_cnt;
    logic [IW-1:0]         r_scan_idx;
    logic                  r_load_ready;
    logic                  r_load_err;
    logic                  r_sec_pulse;
    logic [6:0]            r_segments;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_anodes;

    logic [BW-1:0]         w_time;
    logic                  w_tick;
    logic                  w_load_acc;
    logic                  w_load_legal;
    logic                  w_load_ok;
    logic                  w_adv;
    logic [3:0]            w_cur_digit;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic                  w_unused_wrap;

    assign w_tick     = i_run && (r_presc == PW'(TICK_DIV - 1));
    assign w_load_acc = i_load_valid && r_load_ready;
    assign w_load_ok  = w_load_acc && w_load_legal;
    // A legal load overrides a coincident tick
    assign w_adv      = w_tick && !w_load_ok;

    // Range-check every digit of the requested time
    always_comb begin
        w_load_legal = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i_load_bcd[4*i +: 4] > digit_max(i, NUM_DIGITS, i_load_bcd[BW-1 -: 4])) begin
                w_load_legal = 1'b0;
            end
        end
    end

    // Digit chain: each stage increments on the carry of the stage below
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        logic w_inc;
        logic w_cout;
        if (g == 0) begin : g_first
            assign w_inc = w_adv;
        end else begin : g_chain
            assign w_inc = g_dig[g-1].w_cout;
        end
        bcd_digit_cnt u_cnt (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (w_load_ok),
            .i_load_val (i_load_bcd[4*g +: 4]),
            .i_inc      (w_inc),
            .i_max      (digit_max(g, NUM_DIGITS, w_time[BW-1 -: 4])),
            .o_val      (w_time[4*g +: 4]),
            .o_carry    (w_cout)
        );
    end

    // Rollover of the top digit is the natural day wrap; nothing consumes it
    assign w_unused_wrap = g_dig[NUM_DIGITS-1].w_cout;

    // Prescaler, handshake and strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc      <= '0;
            r_load_ready <= 1'b0;
            r_load_err   <= 1'b0;
            r_sec_pulse  <= 1'b0;
        end else begin
            r_load_ready <= 1'b1;
            r_load_err   <= w_load_acc && !w_load_legal;
            r_sec_pulse  <= w_adv;
            if (w_load_ok) begin
                r_presc <= '0;
            end else if (i_run) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
        end
    end

    // Scan counter and digit index
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    // Pattern and decimal point for the digit currently selected
    always_comb begin
        w_cur_digit = 4'd0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == IW'(i)) w_cur_digit = w_time[4*i +: 4];
        end
        w_seg = bcd_to_seg(w_cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_scan_idx == IW'(NUM_DIGITS - 1) && w_cur_digit == 4'd0) w_seg = SEG_BLANK;
`endif
        w_dp = 1'b1;
        if ((r_scan_idx == IW'(2) || (NUM_DIGITS == 6 && r_scan_idx == IW'(4)))
            && (r_presc < PW'(TICK_DIV / 2))) begin
            w_dp = 1'b0;
        end
    end

    // Registered display drive
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_segments <= SEG_0;
            r_dp       <= 1'b1;
            r_anodes   <= ~NUM_DIGITS'(1);
        end else begin
            r_segments <= w_seg;
            r_dp       <= w_dp;
            r_anodes   <= ~(NUM_DIGITS'(1) << r_scan_idx);
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_load_err   = r_load_err;
    assign o_sec_pulse  = r_sec_pulse;
    assign o_segments   = r_segments;
    assign o_dp         = r_dp;
    assign o_anodes     = r_anodes;

endmodule

// File: tb/tb_seg7_rtc_scan.sv
// Directed bench for seg7_rtc_scan: a 4-digit and a 6-digit instance share clock, reset and run.
module tb_seg7_rtc_scan;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        ld_valid4;
    logic [15:0] ld_bcd4;
    logic        ld_valid6;
    logic [23:0] ld_bcd6;

    logic        ready4, err4, pulse4, dp4;
    logic [6:0]  seg4;
    logic [3:0]  an4;
    logic        ready6, err6, pulse6, dp6;
    logic [6:0]  seg6;
    logic [5:0]  an6;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_rtc_scan #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2)) u_dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_run        (run),
        .i_load_valid (ld_valid4),
        .i_load_bcd   (ld_bcd4),
        .o_load_ready (ready4),
        .o_load_err   (err4),
        .o_sec_pulse  (pulse4),
        .o_segments   (seg4),
        .o_dp         (dp4),
        .o_anodes     (an4)
    );

    seg7_rtc_scan #(.NUM_DIGITS(6), .TICK_DIV(4), .SCAN_DIV(2)) u_dut6 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_run        (run),
        .i_load_valid (ld_valid6),
        .i_load_bcd   (ld_bcd6),
        .o_load_ready (ready6),
        .o_load_err   (err6),
        .o_sec_pulse  (pulse6),
        .o_segments   (seg6),
        .o_dp         (dp6),
        .o_anodes     (an6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dec(input logic [6:0] s);
        case (s)
            7'b1000000: return 4'd0;
            7'b1111111: return 4'd0;  // blanked leading zero
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            default:    return 4'hE;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [15:0] v);
        ld_valid4 = 1'b1;
        ld_bcd4   = v;
        step();
        ld_valid4 = 1'b0;
    endtask

    task automatic load6(input logic [23:0] v);
        ld_valid6 = 1'b1;
        ld_bcd6   = v;
        step();
        ld_valid6 = 1'b0;
    endtask

    // Reconstruct the displayed time by watching one full scan (run must be 0)
    task automatic read4(output logic [15:0] t, output logic ok);
        logic [3:0] seen = '0;
        t = '0;
        for (int c = 0; c < 40 && seen != 4'hF; c++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (an4 == ~(4'b0001 << k)) begin
                    t[4*k +: 4] = dec(seg4);
                    seen[k] = 1'b1;
                end
            end
        end
        ok = (seen == 4'hF);
    endtask

    task automatic read6(output logic [23:0] t, output logic ok);
        logic [5:0] seen = '0;
        t = '0;
        for (int c = 0; c < 60 && seen != 6'h3F; c++) begin
            step();
            for (int k = 0; k < 6; k++) begin
                if (an6 == ~(6'b000001 << k)) begin
                    t[4*k +: 4] = dec(seg6);
                    seen[k] = 1'b1;
                end
            end
        end
        ok = (seen == 6'h3F);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0;
        ld_valid4 = 1'b0; ld_bcd4 = '0; ld_valid6 = 1'b0; ld_bcd6 = '0;
        repeat (3) step();
        n_checks++;
        if ({an4, seg4, dp4, ready4, err4, pulse4} !== {4'b1110, 7'b1000000, 4'b1000}) begin
            $display("FAIL reset4 got an=%b seg=%b dp/rdy/err/pls=%b%b%b%b want 1110 1000000 1000",
                     an4, seg4, dp4, ready4, err4, pulse4);
        end else n_pass++;
        n_checks++;
        if ({an6, seg6, dp6, ready6} !== {6'b111110, 7'b1000000, 2'b10}) begin
            $display("FAIL reset6 got an=%b seg=%b dp=%b rdy=%b want 111110 1000000 1 0",
                     an6, seg6, dp6, ready6);
        end else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready4 !== 1'b0) $display("FAIL ready_before_edge got %b want 0", ready4);
        else n_pass++;
    endtask

    task automatic test_count();
        logic [3:0]  an_exp [12] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                                     4'b0111, 4'b0111, 4'b1110, 4'b1110, 4'b1101, 4'b1101};
        logic [11:0] dp_exp = 12'b111111001111;  // bit k-1 = dp after edge k
        int pulses = 0;
        int bad_an = 0;
        int bad_dp = 0;
        logic [15:0] t;
        logic ok;
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                n_checks++;
                if (ready4 !== 1'b1) $display("FAIL ready_after_edge got %b want 1", ready4);
                else n_pass++;
            end
            if (pulse4 === 1'b1) pulses++;
            if (an4 !== an_exp[k-1]) begin
                bad_an++;
                $display("FAIL scan_anodes edge %0d got %b want %b", k, an4, an_exp[k-1]);
            end
            if (dp4 !== dp_exp[k-1]) begin
                bad_dp++;
                $display("FAIL dp_blink edge %0d got %b want %b", k, dp4, dp_exp[k-1]);
            end
        end
        n_checks++;
        if (bad_an == 0) n_pass++;
        n_checks++;
        if (bad_dp == 0) n_pass++;
        n_checks++;
        if (pulses != 3) $display("FAIL count_pulses got %0d want 3", pulses);
        else n_pass++;
        run = 1'b0;
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h0003) $display("FAIL count_time got %h (ok=%b) want 0003", t, ok);
        else n_pass++;
    endtask

    task automatic test_wrap4();
        int pulses = 0;
        logic [15:0] t;
        logic ok;
        run = 1'b0;
        load4(16'h5958);
        run = 1'b1;
        repeat (4) begin step(); if (pulse4 === 1'b1) pulses++; end
        run = 1'b0;
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h5959) $display("FAIL wrap4_first got %h want 5959", t);
        else n_pass++;
        run = 1'b1;
        repeat (4) begin step(); if (pulse4 === 1'b1) pulses++; end
        run = 1'b0;
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h0000) $display("FAIL wrap4_second got %h want 0000", t);
        else n_pass++;
        n_checks++;
        if (pulses != 2) $display("FAIL wrap4_pulses got %0d want 2", pulses);
        else n_pass++;
        // minute tens of 6 is out of range
        ld_valid4 = 1'b1; ld_bcd4 = 16'h6000;
        step();
        ld_valid4 = 1'b0;
        n_checks++;
        if (err4 !== 1'b1 || ready4 !== 1'b1) begin
            $display("FAIL err4 got err=%b rdy=%b want 1 1", err4, ready4);
        end else n_pass++;
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h0000) $display("FAIL err4_time got %h want 0000", t);
        else n_pass++;
    endtask

    task automatic test_hours6();
        logic [23:0] vecs [4] = '{24'h240000, 24'h006000, 24'h000060, 24'h195959};
        logic        errs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int pulses = 0;
        logic [23:0] t;
        logic ok;
        run = 1'b0;
        load6(24'h235959);
        run = 1'b1;
        repeat (4) begin step(); if (pulse6 === 1'b1) pulses++; end
        run = 1'b0;
        read6(t, ok);
        n_checks++;
        if (!ok || t !== 24'h000000 || pulses != 1) begin
            $display("FAIL day_wrap got %h pulses %0d want 000000 1", t, pulses);
        end else n_pass++;
        // Back-to-back loads, valid held high
        for (int i = 0; i < 4; i++) begin
            ld_valid6 = 1'b1; ld_bcd6 = vecs[i];
            step();
            n_checks++;
            if (err6 !== errs[i] || ready6 !== 1'b1) begin
                $display("FAIL load6_%h got err=%b rdy=%b want %b 1", vecs[i], err6, ready6, errs[i]);
            end else n_pass++;
        end
        ld_valid6 = 1'b0;
        step();
        n_checks++;
        if (err6 !== 1'b0) $display("FAIL err6_one_cycle got %b want 0", err6);
        else n_pass++;
        read6(t, ok);
        n_checks++;
        if (!ok || t !== 24'h195959) $display("FAIL load6_time got %h want 195959", t);
        else n_pass++;
        run = 1'b1;
        repeat (4) step();
        run = 1'b0;
        read6(t, ok);
        n_checks++;
        if (!ok || t !== 24'h200000) $display("FAIL hour_carry got %h want 200000", t);
        else n_pass++;
    endtask

    task automatic test_load_on_tick();
        int bad = 0;
        logic [15:0] t;
        logic ok;
        run = 1'b0;
        load4(16'h0000);
        run = 1'b1;
        repeat (3) step();
        ld_valid4 = 1'b1; ld_bcd4 = 16'h1234;
        step();
        ld_valid4 = 1'b0;
        n_checks++;
        if (pulse4 !== 1'b0) $display("FAIL tick_dropped got pulse %b want 0", pulse4);
        else n_pass++;
        run = 1'b0;
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h1234) $display("FAIL load_on_tick got %h want 1234", t);
        else n_pass++;
        run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (pulse4 !== (k == 4)) begin
                bad++;
                $display("FAIL presc_cleared edge %0d got pulse %b want %b", k, pulse4, k == 4);
            end
        end
        run = 1'b0;
        n_checks++;
        if (bad == 0) n_pass++;
    endtask

    task automatic test_run_stop();
        int pulses = 0;
        int bad_dp = 0;
        logic [3:0] seen = '0;
        logic [15:0] t;
        logic ok;
        run = 1'b0;
        load4(16'h0000);
        run = 1'b1;
        repeat (4) step();
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (pulse4 === 1'b1) pulses++;
            for (int d = 0; d < 4; d++) if (an4 == ~(4'b0001 << d)) seen[d] = 1'b1;
            // prescaler frozen at 0: dp low exactly while digit 2 is lit
            if (dp4 !== (an4 != 4'b1011)) bad_dp++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL stop_pulses got %0d want 0", pulses);
        else n_pass++;
        n_checks++;
        if (seen !== 4'hF) $display("FAIL stop_scan got digits seen %b want 1111", seen);
        else n_pass++;
        n_checks++;
        if (bad_dp != 0) $display("FAIL stop_dp got %0d bad cycles want 0", bad_dp);
        else n_pass++;
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h0001) $display("FAIL stop_time got %h want 0001", t);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] t;
        logic ok;
        run = 1'b0;
        load4(16'h1234);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({an4, seg4, dp4, ready4} !== {4'b1110, 7'b1000000, 2'b10}) begin
            $display("FAIL mid_reset got an=%b seg=%b dp=%b rdy=%b want 1110 1000000 1 0",
                     an4, seg4, dp4, ready4);
        end else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        read4(t, ok);
        n_checks++;
        if (!ok || t !== 16'h0000) $display("FAIL mid_reset_time got %h want 0000", t);
        else n_pass++;
    endtask

    task automatic test_blank();
        logic [6:0] want;
        logic found = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        want = 7'b1111111;
`else
        want = 7'b1000000;
`endif
        run = 1'b0;
        load4(16'h0500);
        for (int c = 0; c < 16 && !found; c++) begin
            step();
            if (an4 == 4'b0111) found = 1'b1;
        end
        n_checks++;
        if (!found || seg4 !== want) begin
            $display("FAIL msd_zero got seg=%b (found=%b) want %b", seg4, found, want);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap4();
        test_hours6();
        test_load_on_tick();
        test_run_stop();
        test_reset_mid();
        test_blank();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_rtc_scan.md
Name: seg7_rtc_scan

Overview:
- Parametrised successor to the four-digit board clock.
- Keeps BCD time of day at either MM:SS (4 digits) or HH:MM:SS (6 digits).
- Drives a time-multiplexed, common-anode seven-segment display.
- Adds a run/stop control, a validated load handshake, a seconds strobe and a blinking colon dot.

Parameters:
- NUM_DIGITS, 4, display digits; legal values 4 (MM:SS) or 6 (HH:MM:SS).
- TICK_DIV, 100000000, clk cycles per second, >=2.
- SCAN_DIV, 100000, clk cycles each digit stays enabled, >=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = time advances; 0 = prescaler frozen, display keeps scanning.
- load_valid  in  1  load request.
- load_bcd  in  4*NUM_DIGITS  new time, digit 0 = seconds units in bits [3:0].
- load_ready  out  1  load accepted when load_valid and load_ready are both 1.
- load_err  out  1  one-cycle pulse when a load is rejected.
- sec_pulse  out  1  one-cycle pulse on each time advance.
- segments  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- anodes  out  NUM_DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
- Reset (reset=0, asynchronous):
  - time all zero; prescaler=0; scan index=0.
  - anodes = all ones except bit0=0; segments=7'b1000000 ("0"); dp=1.
  - load_ready=0; load_err=0; sec_pulse=0.
- After reset release: load_ready=1 from the first clk edge onward.
- Prescaler:
  - counts 0..TICK_DIV-1 while run=1 and wraps to 0.
  - the wrap cycle is the tick: time advances and sec_pulse=1 on the same edge.
  - run=0 holds the prescaler value; no ticks.
- Time digit ranges and carries:
  - sec units 0-9, sec tens 0-5; min units 0-9, min tens 0-5.
  - carries ripple in the same cycle.
  - NUM_DIGITS=4: 59:59 -> 00:00.
  - NUM_DIGITS=6: hours 00-23; 23:59:59 -> 00:00:00.
- Load accept (load_valid=1 and load_ready=1):
  - validated against the ranges above; hours-tens>2, or hours-tens=2 with units>3, is illegal.
  - valid: time <= load_bcd and prescaler <= 0 on the next edge. Load has priority over a simultaneous tick; that tick and its sec_pulse are dropped.
  - invalid: time unchanged, prescaler unaffected, load_err=1 for one cycle.
  - load_ready stays 1; back-to-back accepts are allowed.
- Scan:
  - scan counter counts 0..SCAN_DIV-1.
  - on wrap, scan index advances 0..NUM_DIGITS-1 and wraps to 0.
  - segments, anodes and dp are registered: they reflect the new index and current time one cycle after the index changes.
  - a time change appears on the digit currently lit one cycle after the time update.
- Segment encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- dp:
  - low only when the scanned digit is 2, or 4 (6-digit build), and prescaler < TICK_DIV/2.
  - when run=0 it holds the state frozen with the prescaler.
- Reset mid-operation: everything returns to reset values immediately; a pending load is lost.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: while the most significant digit is scanned and its value is 0, segments=7'b1111111; its anode is still driven, and dp is unaffected.
- Undefined: every digit always shows its value.

Decomposition:
- Package seg7_rtc_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - digit-limit constants (SEC_TENS_MAX=5, HOUR_MAX_TENS=2, HOUR_MAX_UNITS_AT_2=3);
  - a function returning the active-low pattern for a 4-bit BCD value.
- One sub-module, bcd_digit_cnt: a single BCD digit with programmable max, load, increment-enable and carry-out. It is instantiated once per digit, with hours tens/units limits applied by the parent.

Test Plan (TICK_DIV=4, SCAN_DIV=2 unless stated):
- Reset then run=1 for 12 clk -> sec_pulse seen 3 times; time=00:03; anodes cycle 1110,1101,1011,0111, each for 2 clk.
- 4-digit load 0x5958, run=1 for 8 clk -> first tick gives 59:59, second gives 00:00; sec_pulse twice.
- 6-digit load 0x235959, one tick -> 00:00:00; load 0x240000 -> load_err pulse, time unchanged.
- Load 0x1234 on the exact tick cycle -> time=12:34, no sec_pulse that cycle, prescaler=0 next cycle.
- run=0 for 20 clk after 00:01 -> no sec_pulse; time stays 00:01; anodes keep scanning; dp static.
- Assert reset low mid-scan with time 12:34 -> same cycle: anodes=1110, segments=1000000, time reads 00:00 after release. With LEADING_ZERO_BLANK_EN and time 05:00, digit 3 shows 1111111.
